// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: slice opcodes,
// sequencer states and the per-nibble carry helper.
package alu_seq_pkg;

  // Slice function select, encoded exactly as the 74381 S inputs
  localparam logic [2:0] OP_CLEAR  = 3'b000;
  localparam logic [2:0] OP_BMA    = 3'b001;
  localparam logic [2:0] OP_AMB    = 3'b010;
  localparam logic [2:0] OP_ADD    = 3'b011;
  localparam logic [2:0] OP_XOR    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_AND    = 3'b110;
  localparam logic [2:0] OP_PRESET = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ops whose carry ripples between nibbles
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_BMA) || (op == OP_AMB) || (op == OP_ADD);
  endfunction

  // Carry out of one slice from its active-low group P/G and carry in
  function automatic logic nib_carry(input logic p_n, input logic g_n, input logic cn);
    return (~g_n) | ((~p_n) & cn);
  endfunction

endpackage

// File: rtl/alu_nibble_seq.sv
// Nibble-serial sequencer around one external 4-bit 74381-style ALU slice.
// Latches a WIDTH-bit operation, walks the slice LSB nibble first, ripples
// the carry from the slice P/G outputs and assembles the result.
// Optional build macro ALU_SEQ_OVF_EN adds a signed-overflow output (ovf).
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic [2:0]       slice_s,
  output logic             slice_cn,
  input  logic [3:0]       slice_f,
  input  logic             slice_p,
  input  logic             slice_g
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = $clog2(NIB);
  localparam int unsigned BITW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic [IDXW-1:0]  idx;
  logic             carry;

  logic [BITW-1:0]  bit_base;
  logic             last;
  logic             carry_nxt;
  logic [WIDTH-1:0] res_fin;

  // Slice inputs come only from latched registers
  always_comb begin
    bit_base = BITW'({idx, 2'b00});
    slice_a  = a_q[bit_base +: 4];
    slice_b  = b_q[bit_base +: 4];
    slice_s  = op_q;
    slice_cn = carry;
  end

  // Per-step carry and the final assembled word
  always_comb begin
    last      = (idx == IDXW'(NIB - 1));
    carry_nxt = is_arith(op_q) ? nib_carry(slice_p, slice_g, slice_cn) : 1'b0;
    res_fin   = result;
    res_fin[bit_base +: 4] = slice_f;
  end

`ifdef ALU_SEQ_OVF_EN
  logic ae_msb, be_msb, ovf_nxt;

  // Signed overflow on the effective operands seen by the adder
  always_comb begin
    ae_msb = a_q[WIDTH-1];
    be_msb = b_q[WIDTH-1];
    case (op_q)
      OP_BMA:  ae_msb = ~a_q[WIDTH-1];
      OP_AMB:  be_msb = ~b_q[WIDTH-1];
      default: ;
    endcase
    ovf_nxt = is_arith(op_q) & (ae_msb == be_msb) & (res_fin[WIDTH-1] != ae_msb);
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, nibble capture, carry ripple and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_CLEAR;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            idx   <= '0;
            carry <= cin;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          result[bit_base +: 4] <= slice_f;
          carry <= carry_nxt;
          if (last) begin
            cout <= carry_nxt;
            zero <= (res_fin == '0);
            done <= 1'b1;
`ifdef ALU_SEQ_OVF_EN
            ovf  <= ovf_nxt;
`endif
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: a behavioural 74381 slice sits beside the DUT,
// and a word-level model pushes expected results into a scoreboard.
// Build with ALU_SEQ_OVF_EN defined to also cover the ovf output.
module tb_alu_nibble_seq;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, cout, zero;
  logic [W-1:0] result;
  logic [3:0]   slice_a, slice_b, slice_f;
  logic [2:0]   slice_s;
  logic         slice_cn, slice_p, slice_g;
`ifdef ALU_SEQ_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         z;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
    .slice_a(slice_a), .slice_b(slice_b), .slice_s(slice_s), .slice_cn(slice_cn),
    .slice_f(slice_f), .slice_p(slice_p), .slice_g(slice_g)
`ifdef ALU_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  // Behavioural 4-bit slice: returns {p_n, g_n, f}
  function automatic logic [5:0] slice_model(input logic [3:0] sa, input logic [3:0] sbv,
                                             input logic [2:0] s, input logic cn);
    logic [3:0] x, y, f;
    logic [4:0] s5;
    logic       p_n, g_n;
    x = sa; y = sbv; f = 4'h0; p_n = 1'b1; g_n = 1'b1;
    if (s == 3'b001) x = ~sa;
    if (s == 3'b010) y = ~sbv;
    s5 = {1'b0, x} + {1'b0, y};
    case (s)
      3'b001, 3'b010, 3'b011: begin
        f   = s5[3:0] + {3'b000, cn};
        g_n = ~(s5 > 5'd15);
        p_n = ~(s5 >= 5'd15);
      end
      3'b100:  f = sa ^ sbv;
      3'b101:  f = sa | sbv;
      3'b110:  f = sa & sbv;
      3'b111:  f = 4'hF;
      default: f = 4'h0;
    endcase
    return {p_n, g_n, f};
  endfunction

  always_comb {slice_p, slice_g, slice_f} = slice_model(slice_a, slice_b, slice_s, slice_cn);

  // Word-level reference for one whole operation
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input logic ci);
    logic [W:0] t;
    logic       ae, be, ar;
    exp_t       e;
    t = '0; ae = av[W-1]; be = bv[W-1]; ar = 1'b0;
    case (o)
      3'b001: begin t = {1'b0, ~av} + {1'b0, bv} + (W+1)'(ci); ae = ~av[W-1]; ar = 1'b1; end
      3'b010: begin t = {1'b0, av} + {1'b0, ~bv} + (W+1)'(ci); be = ~bv[W-1]; ar = 1'b1; end
      3'b011: begin t = {1'b0, av} + {1'b0, bv} + (W+1)'(ci); ar = 1'b1; end
      3'b100:  t = {1'b0, av ^ bv};
      3'b101:  t = {1'b0, av | bv};
      3'b110:  t = {1'b0, av & bv};
      3'b111:  t = {1'b0, {W{1'b1}}};
      default: t = '0;
    endcase
    e.res = t[W-1:0];
    e.co  = ar & t[W];
    e.z   = (e.res == '0);
    e.ov  = ar & (ae == be) & (e.res[W-1] != ae);
    return e;
  endfunction

  // Runs one operation from a negedge; poke>0 re-pulses start with junk at that RUN cycle
  task automatic do_op(input string name, input logic [2:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic ci, input int poke);
    exp_t e;
    int   n;
    start = 1'b1; op = o; a = av; b = bv; cin = ci;
    sb.push_back(model(o, av, bv, ci));
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      if (n < NIB) begin
        checks++;
        if (slice_a !== 4'(av >> (4*n)) || slice_b !== 4'(bv >> (4*n)) || slice_s !== o)
          $display("FAIL %s slice_in[%0d] got a=%h b=%h s=%b want a=%h b=%h s=%b", name, n,
                   slice_a, slice_b, slice_s, 4'(av >> (4*n)), 4'(bv >> (4*n)), o);
        if (slice_a !== 4'(av >> (4*n)) || slice_b !== 4'(bv >> (4*n)) || slice_s !== o)
          failures++;
      end
      @(negedge clk);
      n++;
      if (poke != 0 && n == poke) begin
        start = 1'b1; op = 3'b011; a = ~av; b = 16'h1111; cin = ~ci;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout got done=%b want done=1 within 20 cycles", name, done);
    end else begin
      checks++;
      if (n != NIB) begin failures++; $display("FAIL %s latency got %0d want %0d", name, n, NIB); end
      checks++;
      if (result !== e.res) begin failures++; $display("FAIL %s result got %h want %h", name, result, e.res); end
      checks++;
      if (cout !== e.co) begin failures++; $display("FAIL %s cout got %b want %b", name, cout, e.co); end
      checks++;
      if (zero !== e.z) begin failures++; $display("FAIL %s zero got %b want %b", name, zero, e.z); end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_in_done got %b want 1", name, busy); end
`ifdef ALU_SEQ_OVF_EN
      checks++;
      if (ovf !== e.ov) begin failures++; $display("FAIL %s ovf got %b want %b", name, ovf, e.ov); end
`endif
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== e.res) begin
      failures++;
      $display("FAIL %s after_done got done=%b busy=%b result=%h want 0 0 %h", name, done, busy, result, e.res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 3'b011; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got busy=%b done=%b result=%h cout=%b zero=%b want all 0",
               busy, done, result, cout, zero);
    end
    checks++;
    if (slice_a !== 4'h0 || slice_b !== 4'h0 || slice_s !== 3'b000 || slice_cn !== 1'b0) begin
      failures++;
      $display("FAIL reset_slice got a=%h b=%h s=%b cn=%b want 0 0 000 0", slice_a, slice_b, slice_s, slice_cn);
    end
`ifdef ALU_SEQ_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_hold busy got %b want 0", busy); end
  endtask

  task automatic test_arith();
    do_op("add_basic",   3'b011, 16'h1234, 16'h0FCD, 1'b0, 0);
    do_op("a_minus_b",   3'b010, 16'h0005, 16'h0007, 1'b1, 0);
    do_op("b_minus_a",   3'b001, 16'h0005, 16'h0007, 1'b1, 0);
    do_op("add_ripple",  3'b011, 16'hFFFF, 16'h0001, 1'b0, 0);
    do_op("add_cin",     3'b011, 16'h00FF, 16'h0F00, 1'b1, 0);
  endtask

  task automatic test_logic();
    do_op("xor",         3'b100, 16'hA5A5, 16'hFFFF, 1'b1, 0);
    do_op("clear",       3'b000, 16'h1234, 16'h5678, 1'b1, 0);
    do_op("preset_cin",  3'b111, 16'h0000, 16'h0000, 1'b1, 0);
    do_op("or",          3'b101, 16'hA000, 16'h0C03, 1'b0, 0);
    do_op("and",         3'b110, 16'hF0F0, 16'h3C3C, 1'b1, 0);
  endtask

  task automatic test_start_ignored();
    do_op("start_mid_run", 3'b011, 16'h1234, 16'h0FCD, 1'b0, 1);
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL start_mid_run_queued got done=%b busy=%b want 0 0", done, busy);
      end
    end
  endtask

  task automatic test_rst_mid_run();
    start = 1'b1; op = 3'b011; a = 16'h4321; b = 16'h1111; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_run got busy=%b done=%b result=%h cout=%b want 0 0 0000 0",
               busy, done, result, cout);
    end
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_run_late_done got %b want 0", done); end
    end
    do_op("after_rst", 3'b011, 16'h4321, 16'h1111, 1'b0, 0);
  endtask

`ifdef ALU_SEQ_OVF_EN
  task automatic test_ovf();
    do_op("ovf_add",     3'b011, 16'h7FFF, 16'h0001, 1'b0, 0);
    do_op("ovf_sub",     3'b010, 16'h8000, 16'h0001, 1'b1, 0);
    do_op("ovf_none",    3'b011, 16'h0003, 16'h0004, 1'b0, 0);
    do_op("ovf_bma",     3'b001, 16'h0001, 16'h8000, 1'b1, 0);
  endtask
`endif

  initial begin
    start = 1'b0; rst = 1'b1; op = 3'b000; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    test_reset();
    test_arith();
    test_logic();
    test_start_ignored();
    test_rst_mid_run();
`ifdef ALU_SEQ_OVF_EN
    test_ovf();
`endif
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
